pc_fetch_unit: RTL
==================

Name: pc_fetch_unit

Overview:
- Program-counter register and instruction-fetch sequencer.
- Holds the current PC, issues word fetches to instruction memory over a req/ready handshake, and presents each fetched instruction with its PC to decode over a valid/ack handshake.
- Advances PC by INC_STEP through the existing incrementer, or redirects on a taken branch or jump.
- Sits directly downstream of the PC incrementer and upstream of decode.

Parameters:
- N, 32, PC and instruction width in bits.
- RESET_PC, 0, PC value loaded on reset.
- INC_STEP, 4, sequential PC advance in bytes. Instantiates the incrementer with a matching N.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  level; leaves IDLE and begins fetching.
- halt  input  1  level; stop fetching after the current instruction is delivered.
- branch_taken  input  1  single-cycle pulse; redirect PC.
- branch_target  input  N  redirect address; bits [1:0] are forced to 0 internally.
- imem_req  output  1  fetch request, registered.
- imem_addr  output  N  fetch address; always equals pc.
- imem_ready  input  1  memory returns imem_rdata this cycle.
- imem_rdata  input  N  fetched instruction word.
- instr  output  N  captured instruction.
- instr_pc  output  N  PC of the captured instruction.
- instr_valid  output  1  instr and instr_pc are valid.
- instr_ack  input  1  decode consumes the instruction.
- pc  output  N  current PC register.
- running  output  1  high in FETCH or HOLD.

Behaviour:
- **Reset** (synchronous, when rst=1 at the edge):
  - state=IDLE, pc=RESET_PC.
  - imem_req=0, instr_valid=0, instr=0, instr_pc=0, running=0.
  - rst overrides every other input.
- **States:** IDLE, FETCH, HOLD, HALTED. Encoding is free.
- **IDLE:**
  - Outputs idle.
  - start=1 -> FETCH next cycle, with imem_req=1 from that cycle.
  - branch_taken in IDLE is ignored.
- **FETCH:**
  - imem_req=1 and imem_addr=pc.
  - Waits any number of cycles for imem_ready.
  - On imem_ready=1 (and no branch_taken): instr<=imem_rdata, instr_pc<=pc, instr_valid<=1, pc<=pc+INC_STEP, imem_req<=0, go to HOLD.
  - Fetch latency is one cycle minimum: imem_ready in the first FETCH cycle gives instr_valid=1 in the next cycle.
- **HOLD:**
  - instr, instr_pc and instr_valid stay stable until instr_ack=1.
  - On ack: instr_valid<=0. Next state is HALTED if halt=1, otherwise FETCH (imem_req<=1).
  - Maximum throughput is one instruction every 2 cycles.
- **HALTED:**
  - Outputs idle; pc is frozen.
  - Only rst exits; start and branch_taken are ignored.
- **Branch redirect** (in FETCH or HOLD, branch_taken=1):
  - pc<={branch_target[N-1:2],2'b00}; instr_valid<=0; go to FETCH with imem_req=1.
  - In FETCH with imem_ready=1 in the same cycle, the returned word is discarded and not captured.
  - In HOLD with instr_ack=1 in the same cycle, the branch wins; the held instruction counts as consumed.
- **Priority:** rst > branch_taken > halt/ack/ready.
- **halt:**
  - Sampled only on HOLD ack.
  - halt asserted during FETCH does not cancel the outstanding fetch; that instruction is still delivered.
- **Arithmetic:** pc+INC_STEP wraps modulo 2^N, so 0xFFFFFFFC -> 0x00000000. No overflow flag.
- **instr_ack** outside HOLD is ignored.
- **imem_addr** never changes while imem_req=1 unless a redirect occurs.

Test Plan:
1. rst=1 for 2 cycles, then start=1 with imem_ready tied to 1 and rdata=0x11,0x22,0x33 -> instr/instr_pc = 0x11/0x0, 0x22/0x4, 0x33/0x8, with instr_valid high every other cycle.
2. imem_ready held low for 3 FETCH cycles -> imem_req=1 and imem_addr=0x4 stable throughout; instr_valid=0 until one cycle after ready.
3. In HOLD at pc=0x8, branch_taken=1 with target=0x103 -> instr_valid=0 next cycle, pc=0x100, imem_addr=0x100; the next delivered instr_pc is 0x100.
4. branch_taken and imem_ready in the same FETCH cycle, target 0x40 -> rdata discarded, instr_valid stays 0, next fetch at 0x40.
5. halt=1 raised mid-FETCH at pc=0x10 -> instruction at 0x10 delivered; after its ack the unit is HALTED, running=0, pc=0x14, and start is ignored.
6. RESET_PC=0xFFFFFFFC, fetch one instruction -> instr_pc=0xFFFFFFFC, pc wraps to 0x00000000. rst asserted in HOLD -> all outputs return to reset values next cycle.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program-counter register and instruction-fetch sequencer.
//
// Holds the current PC, fetches one word at a time from instruction memory
// over a req/ready handshake and hands each fetched word, tagged with its PC,
// to decode over a valid/ack handshake. PC advances by INC_STEP through the
// pc_incrementer, or is redirected by a taken branch/jump.
//
// Ports:
//   clk, rst                 system clock, synchronous active-high reset
//   start                    level; leave IDLE and begin fetching
//   halt                     level; stop after the current instruction is acked
//   branch_taken             pulse; redirect PC to branch_target (word aligned)
//   branch_target[N-1:0]     redirect address, bits [1:0] ignored
//   imem_req                 registered fetch request
//   imem_addr[N-1:0]         fetch address, always equal to pc
//   imem_ready, imem_rdata   memory returns the word this cycle
//   instr, instr_pc          captured instruction and its PC
//   instr_valid, instr_ack   decode handshake
//   pc[N-1:0]                current PC register
//   running                  high while fetching or holding an instruction

module pc_incrementer #(
   parameter int N    = 32,
   parameter int STEP = 4
) (
   input  logic [N-1:0] a,
   output logic [N-1:0] y
);
   // Plain modulo-2^N add; carry out is deliberately dropped.
   assign y = a + N'(STEP);
endmodule

// state  | meaning
// IDLE   | out of reset, waiting for start
// FETCH  | imem_req high at imem_addr=pc, waiting for imem_ready
// HOLD   | instruction presented to decode, waiting for instr_ack
// HALTED | stopped after a halted ack; only rst leaves this state
module pc_fetch_unit #(
   parameter int           N        = 32,
   parameter logic [N-1:0] RESET_PC = '0,
   parameter int           INC_STEP = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         halt,
   input  logic         branch_taken,
   input  logic [N-1:0] branch_target,
   output logic         imem_req,
   output logic [N-1:0] imem_addr,
   input  logic         imem_ready,
   input  logic [N-1:0] imem_rdata,
   output logic [N-1:0] instr,
   output logic [N-1:0] instr_pc,
   output logic         instr_valid,
   input  logic         instr_ack,
   output logic [N-1:0] pc,
   output logic         running
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_FETCH  = 2'd1,
      S_HOLD   = 2'd2,
      S_HALTED = 2'd3
   } state_t;

   state_t       state, state_n;
   logic [N-1:0] pc_n, pc_inc, instr_n, instr_pc_n, redirect_pc;
   logic         valid_n, req_n;

   pc_incrementer #(.N(N), .STEP(INC_STEP)) u_inc (
      .a (pc),
      .y (pc_inc)
   );

   assign redirect_pc = {branch_target[N-1:2], 2'b00};
   assign imem_addr   = pc;
   assign running     = (state == S_FETCH) || (state == S_HOLD);

   always_comb begin
      state_n    = state;
      pc_n       = pc;
      instr_n    = instr;
      instr_pc_n = instr_pc;
      valid_n    = instr_valid;
      req_n      = imem_req;
      unique case (state)
         S_IDLE: begin
            if (start) begin
               state_n = S_FETCH;
               req_n   = 1'b1;
            end
         end
         S_FETCH: begin
            // A branch in the same cycle as imem_ready discards the word.
            if (branch_taken) begin
               pc_n    = redirect_pc;
               valid_n = 1'b0;
               req_n   = 1'b1;
            end else if (imem_ready) begin
               instr_n    = imem_rdata;
               instr_pc_n = pc;
               valid_n    = 1'b1;
               pc_n       = pc_inc;
               req_n      = 1'b0;
               state_n    = S_HOLD;
            end
         end
         S_HOLD: begin
            // Branch beats ack; the held instruction is treated as consumed.
            if (branch_taken) begin
               pc_n    = redirect_pc;
               valid_n = 1'b0;
               req_n   = 1'b1;
               state_n = S_FETCH;
            end else if (instr_ack) begin
               valid_n = 1'b0;
               if (halt) begin
                  state_n = S_HALTED;
                  req_n   = 1'b0;
               end else begin
                  state_n = S_FETCH;
                  req_n   = 1'b1;
               end
            end
         end
         S_HALTED: begin
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         pc          <= RESET_PC;
         instr       <= '0;
         instr_pc    <= '0;
         instr_valid <= 1'b0;
         imem_req    <= 1'b0;
      end else begin
         state       <= state_n;
         pc          <= pc_n;
         instr       <= instr_n;
         instr_pc    <= instr_pc_n;
         instr_valid <= valid_n;
         imem_req    <= req_n;
      end
   end

endmodule
